shift_sequencer: RTL and testbench

- Multi-cycle shift/rotate unit for the 16-bit datapath.
- Decomposes a 4-bit shift amount into power-of-two stages of 1, 2, 4 and 8, and applies one stage per clock to an internal working register, reusing a single conditional stage instead of a full combinational barrel.
- Sits beside the ALU; the execute-stage control starts it with a start pulse and waits for done.

---
 rtl/shift_sequencer.sv | 108 ++++++++++
 tb/tb_shift_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 16-bit shift/rotate unit.
// The 4-bit amount is applied as four conditional power-of-two stages
// (1, 2, 4, 8), one stage per clock, through a single shared stage.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start
// S_SHIFT | applying stage k (k = 0..3) to the working register
// S_DONE  | result in out, done pulses; start here chains a new job
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int K_W = $clog2(CNT_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;

    localparam logic [K_W-1:0] K_LAST = K_W'(CNT_W - 1);

    logic [1:0]       r_state;
    logic [K_W-1:0]   r_k;
    logic [WIDTH-1:0] r_work;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out;

    logic [1:0]       w_next_state;
    logic             w_accept;
    logic [CNT_W:0]   w_sh;
    logic [CNT_W:0]   w_inv;
    logic [WIDTH-1:0] w_stage;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Next-state selection.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:  w_next_state = start ? S_SHIFT : S_IDLE;
            S_SHIFT: w_next_state = (r_k == K_LAST) ? S_DONE : S_SHIFT;
            S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Shared stage: shift/rotate by 2^k when the latched amount bit k is set.
    always_comb begin
        w_sh  = (CNT_W + 1)'(1) << r_k;
        w_inv = (CNT_W + 1)'(WIDTH) - w_sh;
        case (r_op)
            OP_ROL:  w_stage = (r_work << w_sh) | (r_work >> w_inv);
            OP_SLL:  w_stage = r_work << w_sh;
            OP_ROR:  w_stage = (r_work >> w_sh) | (r_work << w_inv);
            default: w_stage = r_work >> w_sh;
        endcase
        if (!r_cnt[r_k]) begin
            w_stage = r_work;
        end
    end

    // State, job latch, stage sequencing and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_work  <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_work <= in;
                r_op   <= op;
                r_cnt  <= cnt;
                r_k    <= '0;
            end else if (r_state == S_SHIFT) begin
                r_work <= w_stage;
                r_k    <= r_k + 1'b1;
                if (r_k == K_LAST) begin
                    r_out <= w_stage;
                end
            end
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign out  = r_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results and cycle timing.
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] d_in;
    logic [3:0]  cnt;
    logic        busy;
    logic        done;
    logic [15:0] d_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] last_out;

    shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .in    (d_in),
        .cnt   (cnt),
        .busy  (busy),
        .done  (done),
        .out   (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full job: accept, four busy cycles with out held, done pulse, done low.
    task automatic run_job(input string tag, input logic [1:0] o, input logic [15:0] a,
                           input logic [3:0] c, input logic [15:0] exp);
        @(negedge clk);
        start = 1'b1; op = o; d_in = a; cnt = c;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; d_in = ~a; cnt = ~c;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
            chk({tag, "_nodone"}, {15'd0, done}, 16'd0);
            chk({tag, "_hold"}, d_out, last_out);
            @(posedge clk); #1;
        end
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
        chk({tag, "_out"}, d_out, exp);
        last_out = exp;
        @(posedge clk); #1;
        chk({tag, "_done_low"}, {15'd0, done}, 16'd0);
        chk({tag, "_out_kept"}, d_out, exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; d_in = 16'h0; cnt = 4'h0;
        last_out = 16'h0000;
        #12;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_out", d_out, 16'h0000);
        @(negedge clk); rst_n = 1'b1;

        run_job("sll15", 2'b01, 16'h0001, 4'hF, 16'h8000);
        run_job("rol1",  2'b00, 16'h8001, 4'h1, 16'h0003);
        run_job("ror4",  2'b10, 16'h0001, 4'h4, 16'h1000);
        run_job("srl15", 2'b11, 16'h8000, 4'hF, 16'h0001);
        run_job("srl0",  2'b11, 16'hA5A5, 4'h0, 16'hA5A5);
        run_job("rol15", 2'b00, 16'h0001, 4'hF, 16'h8000);
        run_job("ror15", 2'b10, 16'h0001, 4'hF, 16'h0002);
        run_job("sll5",  2'b01, 16'h1234, 4'h5, 16'h4680);

        // Start while busy, then back-to-back start in the DONE cycle.
        @(negedge clk);
        start = 1'b1; op = 2'b01; d_in = 16'h00FF; cnt = 4'h8;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_busy0", {15'd0, busy}, 16'd1);
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; d_in = 16'h1111; cnt = 4'h3;
        chk("ign_busy1", {15'd0, busy}, 16'd1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_busy2", {15'd0, busy}, 16'd1);
        chk("ign_nodone2", {15'd0, done}, 16'd0);
        @(posedge clk); #1;
        chk("ign_busy3", {15'd0, busy}, 16'd1);
        chk("ign_nodone3", {15'd0, done}, 16'd0);
        @(posedge clk); #1;
        chk("ign_done", {15'd0, done}, 16'd1);
        chk("ign_out", d_out, 16'hFF00);
        start = 1'b1; op = 2'b10; d_in = 16'h1234; cnt = 4'h8;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", {15'd0, busy}, 16'd1);
        chk("b2b_nodone", {15'd0, done}, 16'd0);
        chk("b2b_out_held", d_out, 16'hFF00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b2b_busy_n", {15'd0, busy}, 16'd1);
        end
        @(posedge clk); #1;
        chk("b2b_done", {15'd0, done}, 16'd1);
        chk("b2b_out", d_out, 16'h3412);
        last_out = 16'h3412;
        @(posedge clk); #1;

        // Asynchronous reset while in SHIFT with k=2.
        @(negedge clk);
        start = 1'b1; op = 2'b01; d_in = 16'h0F0F; cnt = 4'h3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("arst_pre_busy", {15'd0, busy}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", {15'd0, busy}, 16'd0);
        chk("arst_done", {15'd0, done}, 16'd0);
        chk("arst_out", d_out, 16'h0000);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("arst_no_done", {15'd0, done}, 16'd0);
            chk("arst_no_busy", {15'd0, busy}, 16'd0);
        end
        last_out = 16'h0000;
        run_job("post_rst", 2'b01, 16'h0F0F, 4'h3, 16'h7878);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
